// File: rtl/sparc_exu_ccrfile.sv
// Per-thread condition-code register file for the integer execution unit.
//
// Holds one CCW-bit CCR per thread. It tracks CC-setting instructions
// through the D/E/M/W pipeline and forwards in-flight condition codes to
// the D-stage reader. The TLU restores CCRs in M, WRCCR writes them in W,
// and the divider writes back out of band in W2. Per-thread divider-pending
// flags stall D-stage CC readers until the divider result arrives.
//
// Ports
//   clk, arst_l              clock, asynchronous active-low reset
//   ifu_exu_setcc_d          D-stage instruction writes CC
//   tid_d                    D-stage thread (also the read thread)
//   ifu_exu_rdcc_d           D-stage instruction reads CC
//   ifu_exu_kill_e           kills the E-stage instruction
//   alu_cc_e                 ALU condition codes, E stage
//   tlu_exu_cwpccr_update_m  TLU CCR restore, M stage, for thread tid_m
//   tlu_exu_ccr_m            TLU restore data
//   ifu_exu_inst_vld_w       W-stage instruction valid
//   ifu_tlu_flush_w          W-stage flush
//   early_flush_w            W-stage early flush
//   wrccr_w, wrccr_data_w    WRCCR write, W stage
//   div_start_e              divider accepted a setcc op for thread tid_e
//   div_cc_vld_w2            divider CC writeback valid
//   div_tid_w2, div_cc_w2    divider writeback thread and data
//   exu_ifu_cc_d             bypassed CC for tid_d (combinational)
//   exu_tlu_ccr_w            stored CCRs, thread t at [t*CCW +: CCW]
//   exu_ifu_cc_stall_d       D-stage CC read must wait for the divider
//   div_pend                 per-thread divider-pending flags

module sparc_exu_ccrfile #(
  parameter  int unsigned TIDW = 2,
  parameter  int unsigned CCW  = 8,
  // Thread-id ports stay one bit wide in single-thread builds; the value is ignored then.
  localparam int unsigned TW   = (TIDW == 0) ? 1 : TIDW,
  localparam int unsigned NTHR = 1 << TIDW
) (
  input  logic                 clk,
  input  logic                 arst_l,
  input  logic                 ifu_exu_setcc_d,
  input  logic [TW-1:0]        tid_d,
  input  logic                 ifu_exu_rdcc_d,
  input  logic                 ifu_exu_kill_e,
  input  logic [CCW-1:0]       alu_cc_e,
  input  logic                 tlu_exu_cwpccr_update_m,
  input  logic [CCW-1:0]       tlu_exu_ccr_m,
  input  logic                 ifu_exu_inst_vld_w,
  input  logic                 ifu_tlu_flush_w,
  input  logic                 early_flush_w,
  input  logic                 wrccr_w,
  input  logic [CCW-1:0]       wrccr_data_w,
  input  logic                 div_start_e,
  input  logic                 div_cc_vld_w2,
  input  logic [TW-1:0]        div_tid_w2,
  input  logic [CCW-1:0]       div_cc_w2,
  output logic [CCW-1:0]       exu_ifu_cc_d,
  output logic [NTHR*CCW-1:0]  exu_tlu_ccr_w,
  output logic                 exu_ifu_cc_stall_d,
  output logic [NTHR-1:0]      div_pend
);

  // Thread match; with a single thread every access targets thread 0.
  function automatic logic tid_eq(input logic [TW-1:0] a, input logic [TW-1:0] b);
    return (TIDW == 0) || (a == b);
  endfunction

  // Pipeline state
  logic            setcc_e, setcc_m, setcc_w;
  logic [TW-1:0]   tid_e, tid_m, tid_w;
  logic [CCW-1:0]  cc_m, cc_w;

  // Architectural state
  logic [CCW-1:0]  ccr_q [NTHR];
  logic [CCW-1:0]  ccr_nxt [NTHR];
  logic [NTHR-1:0] div_pend_nxt;

  // Stage qualifiers
  logic            valid_e;
  logic            setcc_mx;
  logic [CCW-1:0]  cc_mx;
  logic            w_commit;
  logic [CCW-1:0]  w_data;
  logic            w2_hit_d;

  // Read-side
  logic [CCW-1:0]  ccr_rd;
  logic            pend_rd;
  logic [CCW-1:0]  cc_byp;

  // Stage qualification: kill drops E, TLU restore merges into M, W needs a clean commit.
  always_comb begin
    valid_e  = setcc_e & ~ifu_exu_kill_e;
    setcc_mx = setcc_m | tlu_exu_cwpccr_update_m;
    cc_mx    = tlu_exu_cwpccr_update_m ? tlu_exu_ccr_m : cc_m;
    w_commit = ifu_exu_inst_vld_w & ~ifu_tlu_flush_w & ~early_flush_w & (setcc_w | wrccr_w);
    w_data   = wrccr_w ? wrccr_data_w : cc_w;
    w2_hit_d = div_cc_vld_w2 & tid_eq(div_tid_w2, tid_d);
  end

  // Next-state for CCR storage and divider-pending flags.
  // W2 overrides W on the same thread; a divider start beats a same-cycle clear.
  always_comb begin
    div_pend_nxt = div_pend;
    for (int unsigned t = 0; t < NTHR; t++) begin
      ccr_nxt[t] = ccr_q[t];
      if (div_cc_vld_w2 && tid_eq(div_tid_w2, TW'(t))) begin
        ccr_nxt[t] = div_cc_w2;
      end else if (w_commit && tid_eq(tid_w, TW'(t))) begin
        ccr_nxt[t] = w_data;
      end
      if (div_start_e && !ifu_exu_kill_e && tid_eq(tid_e, TW'(t))) begin
        div_pend_nxt[t] = 1'b1;
      end else if (div_cc_vld_w2 && tid_eq(div_tid_w2, TW'(t))) begin
        div_pend_nxt[t] = 1'b0;
      end
    end
  end

  // Pipeline flops D->E->M->W.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      setcc_e <= 1'b0;
      setcc_m <= 1'b0;
      setcc_w <= 1'b0;
      tid_e   <= '0;
      tid_m   <= '0;
      tid_w   <= '0;
      cc_m    <= '0;
      cc_w    <= '0;
    end else begin
      setcc_e <= ifu_exu_setcc_d;
      setcc_m <= valid_e;
      setcc_w <= setcc_mx;
      tid_e   <= tid_d;
      tid_m   <= tid_e;
      tid_w   <= tid_m;
      cc_m    <= alu_cc_e;
      cc_w    <= cc_mx;
    end
  end

  // CCR storage and divider-pending flags.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      div_pend <= '0;
      for (int unsigned t = 0; t < NTHR; t++) begin
        ccr_q[t] <= '0;
      end
    end else begin
      div_pend <= div_pend_nxt;
      for (int unsigned t = 0; t < NTHR; t++) begin
        ccr_q[t] <= ccr_nxt[t];
      end
    end
  end

  // Stored-value read for tid_d, and the flat storage view for the TLU.
  always_comb begin
    ccr_rd        = '0;
    pend_rd       = 1'b0;
    exu_tlu_ccr_w = '0;
    for (int unsigned t = 0; t < NTHR; t++) begin
      exu_tlu_ccr_w[t*CCW +: CCW] = ccr_q[t];
      if (tid_eq(tid_d, TW'(t))) begin
        ccr_rd  = ccr_q[t];
        pend_rd = div_pend[t];
      end
    end
  end

  // Bypass: youngest in-flight producer of tid_d wins.
  always_comb begin
    cc_byp = ccr_rd;
    if (valid_e && tid_eq(tid_e, tid_d)) begin
      cc_byp = alu_cc_e;
    end else if (setcc_mx && tid_eq(tid_m, tid_d)) begin
      cc_byp = cc_mx;
    end else if (w2_hit_d) begin
      cc_byp = div_cc_w2;
    end else if (w_commit && tid_eq(tid_w, tid_d)) begin
      cc_byp = w_data;
    end
  end

  // Raw M/W2/W inputs can still bypass while reset is held, so the read port is forced to zero.
  assign exu_ifu_cc_d = arst_l ? cc_byp : '0;

  // A same-cycle divider writeback is bypassed, so it resolves the stall.
  assign exu_ifu_cc_stall_d = ifu_exu_rdcc_d & pend_rd & ~w2_hit_d;

endmodule

// File: tb/tb_sparc_exu_ccrfile.sv
module tb_sparc_exu_ccrfile;

  localparam int unsigned TIDW = 2;
  localparam int unsigned CCW  = 8;
  localparam int unsigned NTHR = 4;

  logic                 clk = 1'b0;
  logic                 arst_l;
  logic                 ifu_exu_setcc_d;
  logic [TIDW-1:0]      tid_d;
  logic                 ifu_exu_rdcc_d;
  logic                 ifu_exu_kill_e;
  logic [CCW-1:0]       alu_cc_e;
  logic                 tlu_exu_cwpccr_update_m;
  logic [CCW-1:0]       tlu_exu_ccr_m;
  logic                 ifu_exu_inst_vld_w;
  logic                 ifu_tlu_flush_w;
  logic                 early_flush_w;
  logic                 wrccr_w;
  logic [CCW-1:0]       wrccr_data_w;
  logic                 div_start_e;
  logic                 div_cc_vld_w2;
  logic [TIDW-1:0]      div_tid_w2;
  logic [CCW-1:0]       div_cc_w2;
  logic [CCW-1:0]       exu_ifu_cc_d;
  logic [NTHR*CCW-1:0]  exu_tlu_ccr_w;
  logic                 exu_ifu_cc_stall_d;
  logic [NTHR-1:0]      div_pend;

  int n_chk = 0;
  int n_err = 0;

  // Scoreboard: what to look at, which thread, expected value, tag
  int          q_sel[$];
  int          q_thr[$];
  logic [31:0] q_exp[$];
  string       q_tag[$];

  always #5 clk = ~clk;

  sparc_exu_ccrfile #(.TIDW(TIDW), .CCW(CCW)) dut (
    .clk                     (clk),
    .arst_l                  (arst_l),
    .ifu_exu_setcc_d         (ifu_exu_setcc_d),
    .tid_d                   (tid_d),
    .ifu_exu_rdcc_d          (ifu_exu_rdcc_d),
    .ifu_exu_kill_e          (ifu_exu_kill_e),
    .alu_cc_e                (alu_cc_e),
    .tlu_exu_cwpccr_update_m (tlu_exu_cwpccr_update_m),
    .tlu_exu_ccr_m           (tlu_exu_ccr_m),
    .ifu_exu_inst_vld_w      (ifu_exu_inst_vld_w),
    .ifu_tlu_flush_w         (ifu_tlu_flush_w),
    .early_flush_w           (early_flush_w),
    .wrccr_w                 (wrccr_w),
    .wrccr_data_w            (wrccr_data_w),
    .div_start_e             (div_start_e),
    .div_cc_vld_w2           (div_cc_vld_w2),
    .div_tid_w2              (div_tid_w2),
    .div_cc_w2               (div_cc_w2),
    .exu_ifu_cc_d            (exu_ifu_cc_d),
    .exu_tlu_ccr_w           (exu_tlu_ccr_w),
    .exu_ifu_cc_stall_d      (exu_ifu_cc_stall_d),
    .div_pend                (div_pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // sel: 0 cc_d, 1 stall, 2 stored CCR of thread thr, 3 div_pend vector
  task automatic push(input int sel, input int thr, input logic [31:0] exp, input string tag);
    q_sel.push_back(sel);
    q_thr.push_back(thr);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
  endtask

  task automatic drain();
    int          sel;
    int          thr;
    logic [31:0] exp;
    logic [31:0] obs;
    string       tag;
    while (q_sel.size() > 0) begin
      sel = q_sel.pop_front();
      thr = q_thr.pop_front();
      exp = q_exp.pop_front();
      tag = q_tag.pop_front();
      case (sel)
        0:       obs = 32'(exu_ifu_cc_d);
        1:       obs = 32'(exu_ifu_cc_stall_d);
        2:       obs = 32'(exu_tlu_ccr_w[thr*CCW +: CCW]);
        default: obs = 32'(div_pend);
      endcase
      chk(tag, obs, exp);
    end
  endtask

  // Compare on the falling edge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifu_exu_setcc_d         = 1'b0;
    tid_d                   = '0;
    ifu_exu_rdcc_d          = 1'b0;
    ifu_exu_kill_e          = 1'b0;
    alu_cc_e                = '0;
    tlu_exu_cwpccr_update_m = 1'b0;
    tlu_exu_ccr_m           = '0;
    ifu_exu_inst_vld_w      = 1'b0;
    ifu_tlu_flush_w         = 1'b0;
    early_flush_w           = 1'b0;
    wrccr_w                 = 1'b0;
    wrccr_data_w            = '0;
    div_start_e             = 1'b0;
    div_cc_vld_w2           = 1'b0;
    div_tid_w2              = '0;
    div_cc_w2               = '0;
  endtask

  // One setcc instruction for thread tid through D/E/M/W, reading tid each stage.
  // ee/em/ew: cc_d in E/M/W; ep: stored value during W; es: stored value afterwards.
  task automatic run(input int tid, input logic [7:0] alu, input logic kill, input logic flush,
                     input logic wr, input logic [7:0] wrd,
                     input logic w2, input int w2tid, input logic [7:0] w2cc,
                     input logic [7:0] ee, input logic [7:0] em, input logic [7:0] ew,
                     input logic [7:0] ep, input logic [7:0] es, input string nm);
    idle(); ifu_exu_setcc_d = 1'b1; tid_d = TIDW'(tid);
    step();
    idle(); tid_d = TIDW'(tid); alu_cc_e = alu; ifu_exu_kill_e = kill;
    push(0, 0, 32'(ee), {nm, "_cc_e"});
    step();
    idle(); tid_d = TIDW'(tid); alu_cc_e = 8'h33;
    push(0, 0, 32'(em), {nm, "_cc_m"});
    step();
    idle(); tid_d = TIDW'(tid); ifu_exu_inst_vld_w = 1'b1; ifu_tlu_flush_w = flush;
    wrccr_w = wr; wrccr_data_w = wrd;
    div_cc_vld_w2 = w2; div_tid_w2 = TIDW'(w2tid); div_cc_w2 = w2cc;
    push(0, 0, 32'(ew), {nm, "_cc_w"});
    push(2, tid, 32'(ep), {nm, "_ccr_during_w"});
    step();
    idle(); tid_d = TIDW'(tid);
    push(2, tid, 32'(es), {nm, "_ccr_after"});
    push(0, 0, 32'(es), {nm, "_cc_after"});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    arst_l = 1'b0;
    #3;
    push(0, 0, 0, "rst_cc_d");
    push(1, 0, 0, "rst_stall");
    push(3, 0, 0, "rst_div_pend");
    for (int t = 0; t < 4; t++) push(2, t, 0, "rst_ccr");
    drain();
    @(posedge clk); #1;
    arst_l = 1'b1;

    // Basic setcc, then kill and flush variants on the same thread
    run(1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h5A, "basic");
    run(1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, "kill");
    run(1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h5A, "flush");
    // W and W2 collide on thread 2: divider data wins
    run(2, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2, 8'h22, 8'h11, 8'h11, 8'h22, 8'h00, 8'h22, "w_w2_same");
    // W thread 0 and W2 thread 3 in the same cycle: both stored
    run(0, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3, 8'h66, 8'h44, 8'h44, 8'h44, 8'h00, 8'h44, "w_w2_diff");
    idle(); push(2, 3, 32'h66, "w_w2_diff_thr3"); step();
    // WRCCR overrides the pipeline CC
    run(0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 0, 8'h00, 8'h77, 8'h77, 8'h99, 8'h44, 8'h99, "wrccr");

    // Divider pending and stall on thread 3
    idle(); tid_d = 2'd3; step();
    idle(); tid_d = 2'd3; div_start_e = 1'b1;
    push(3, 0, 0, "div_pend_pre"); push(1, 0, 0, "stall_no_rdcc"); step();
    idle(); tid_d = 2'd3; ifu_exu_rdcc_d = 1'b1;
    push(3, 0, 32'h8, "div_pend_set"); push(1, 0, 1, "stall_pending"); step();
    idle(); tid_d = 2'd2; ifu_exu_rdcc_d = 1'b1;
    push(1, 0, 0, "stall_other_thr"); step();
    idle(); tid_d = 2'd3; ifu_exu_rdcc_d = 1'b1;
    push(1, 0, 1, "stall_pending2"); step();
    idle(); tid_d = 2'd3; ifu_exu_rdcc_d = 1'b1;
    div_cc_vld_w2 = 1'b1; div_tid_w2 = 2'd3; div_cc_w2 = 8'h0F;
    push(1, 0, 0, "stall_w2_same_cyc"); push(0, 0, 32'h0F, "cc_w2_bypass");
    push(3, 0, 32'h8, "div_pend_hold"); step();
    idle(); tid_d = 2'd3; ifu_exu_rdcc_d = 1'b1;
    push(3, 0, 0, "div_pend_clr"); push(1, 0, 0, "stall_clr");
    push(2, 3, 32'h0F, "ccr3_div"); push(0, 0, 32'h0F, "cc_d_div"); step();

    // Killed divider start does not set pending
    idle(); tid_d = 2'd1; step();
    idle(); div_start_e = 1'b1; ifu_exu_kill_e = 1'b1; step();
    idle(); push(3, 0, 0, "div_pend_killed"); step();

    // Same-cycle set and clear on thread 1: set wins, W2 data still stored
    idle(); tid_d = 2'd1; step();
    idle(); div_start_e = 1'b1; div_cc_vld_w2 = 1'b1; div_tid_w2 = 2'd1; div_cc_w2 = 8'h12; step();
    idle(); push(3, 0, 32'h2, "div_pend_set_wins"); push(2, 1, 32'h12, "ccr1_w2"); step();
    idle(); div_cc_vld_w2 = 1'b1; div_tid_w2 = 2'd1; div_cc_w2 = 8'h5A; step();
    idle(); push(3, 0, 0, "div_pend_clr1"); push(2, 1, 32'h5A, "ccr1_w2b"); step();

    // TLU restore in M for thread 0
    idle(); tid_d = 2'd0; step();
    idle(); tid_d = 2'd0; step();
    idle(); tid_d = 2'd0; tlu_exu_cwpccr_update_m = 1'b1; tlu_exu_ccr_m = 8'hC3;
    push(0, 0, 32'hC3, "tlu_m_bypass"); step();
    idle(); tid_d = 2'd0; ifu_exu_inst_vld_w = 1'b1;
    push(0, 0, 32'hC3, "tlu_w_bypass"); push(2, 0, 32'h99, "tlu_ccr_pre"); step();
    idle(); tid_d = 2'd0; push(2, 0, 32'hC3, "tlu_ccr_after"); step();

    // Mid-stream reset with div_pend = 1010
    idle(); tid_d = 2'd1; step();
    idle(); tid_d = 2'd3; div_start_e = 1'b1; step();
    idle(); div_start_e = 1'b1; step();
    idle(); push(3, 0, 32'hA, "div_pend_1010"); step();
    idle(); tid_d = 2'd0; div_cc_vld_w2 = 1'b1; div_tid_w2 = 2'd0; div_cc_w2 = 8'hFF;
    #1;
    push(0, 0, 32'hFF, "pre_rst_bypass"); drain();
    arst_l = 1'b0;
    #1;
    push(0, 0, 0, "arst_cc_d"); push(1, 0, 0, "arst_stall"); push(3, 0, 0, "arst_div_pend");
    for (int t = 0; t < 4; t++) push(2, t, 0, "arst_ccr");
    drain();
    idle();
    @(posedge clk); #1;
    arst_l = 1'b1;
    run(1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h5A, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sparc_exu_ccrfile.md
SPARC_EXU_CCRFILE -- requirements
Module: sparc_exu_ccrfile

Interface
REQ-001 Parameter TIDW, default 2: thread-id width; NTHR = 2**TIDW threads (legal TIDW 0..3; TIDW=0 means one thread and no tid compares).
REQ-002 Parameter CCW, default 8: condition-code width, {xcc,icc} when 8.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 arst_l  in  1  asynchronous active-low reset.
REQ-005 ifu_exu_setcc_d  in  1  D-stage instruction writes CC.
REQ-006 tid_d  in  TIDW  D-stage thread; also the read thread.
REQ-007 ifu_exu_rdcc_d  in  1  D-stage instruction consumes CC.
REQ-008 ifu_exu_kill_e  in  1  kills the E-stage instruction.
REQ-009 alu_cc_e  in  CCW  ALU condition codes, E stage.
REQ-010 tlu_exu_cwpccr_update_m, tlu_exu_ccr_m  in  1, CCW  TLU CCR restore, M stage, thread = tid_m.
REQ-011 ifu_exu_inst_vld_w, ifu_tlu_flush_w, early_flush_w  in  1 each  W-stage qualifiers.
REQ-012 wrccr_w, wrccr_data_w  in  1, CCW  WRCCR write, W stage.
REQ-013 div_start_e  in  1  divider accepted a setcc op for thread tid_e (unqualified by kill).
REQ-014 div_cc_vld_w2, div_tid_w2, div_cc_w2  in  1, TIDW, CCW  divider CC writeback.
REQ-015 exu_ifu_cc_d  out  CCW  bypassed CC for tid_d.
REQ-016 exu_tlu_ccr_w  out  NTHR*CCW  stored CCR, thread t at bits [t*CCW +: CCW].
REQ-017 exu_ifu_cc_stall_d  out  1  D-stage CC read must stall (divider result pending).
REQ-018 div_pend  out  NTHR  per-thread divider-pending flags.

Function
REQ-019 Pipeline: setcc and tid shall be flopped D->E->M->W internally; alu CC flopped E->M, M-stage CC flopped M->W.
REQ-020 valid_e = setcc_e & ~ifu_exu_kill_e; only valid_e propagates to setcc_m.
REQ-021 M stage: cc_m' = tlu_exu_cwpccr_update_m ? tlu_exu_ccr_m : cc_m; setcc_m' = setcc_m | tlu_exu_cwpccr_update_m; both feed the W flops.
REQ-022 W commit = inst_vld_w & ~flush_w & ~early_flush_w & (setcc_w | wrccr_w); data = wrccr_w ? wrccr_data_w : cc_w.
REQ-023 W2 commit = div_cc_vld_w2; writes div_cc_w2 into thread div_tid_w2 at the same edge.
REQ-024 W and W2 to the same thread in the same cycle: W2 data stored, W data dropped; different threads: both stored.
REQ-025 Non-written threads hold their value.
REQ-026 Read/bypass priority for tid_d, highest first:
- E: valid_e & tid_e==tid_d -> alu_cc_e.
- M: setcc_m' & tid_m==tid_d -> cc_m'.
- W2: div_cc_vld_w2 & div_tid_w2==tid_d -> div_cc_w2.
- W: W commit & tid_w==tid_d -> W data.
- Otherwise: stored CCR[tid_d].
REQ-027 Bypass is combinational, zero-cycle; a stored write is visible from storage one cycle after commit.
REQ-028 div_pend[t] set on div_start_e & ~ifu_exu_kill_e & tid_e==t.
- Cleared on div_cc_vld_w2 & div_tid_w2==t.
- Set and clear of the same thread in the same cycle: set wins.
REQ-029 exu_ifu_cc_stall_d = ifu_exu_rdcc_d & div_pend[tid_d] & ~(div_cc_vld_w2 & div_tid_w2==tid_d); the W2 bypass resolves the same-cycle case.
REQ-030 div_cc_vld_w2 for a thread with div_pend clear shall still write (TLU/diag use); no error flagged.
REQ-031 exu_tlu_ccr_w reflects storage only, never bypass.

Reset
REQ-032 arst_l low shall asynchronously clear all CCRs, all pipeline valid/setcc flops, tid and CC pipeline flops, and div_pend.
REQ-033 During reset: exu_ifu_cc_d=0, exu_tlu_ccr_w=0, exu_ifu_cc_stall_d=0, div_pend=0.
REQ-034 First edge after deassertion behaves normally; an instruction in flight at reset assertion is lost.

Verification
REQ-035 setcc_d tid 1, alu_cc_e=0x5A, no kill, vld_w -> cc_d(tid_d=1) 0x5A at E, M and W stages; ccr_w[15:8]=0x5A from the following cycle.
REQ-036 Same sequence with kill_e=1, or with flush_w=1 -> ccr_w[15:8] unchanged; E bypass absent under kill; no W bypass under flush.
REQ-037 W commit thread 2 = 0x11 and W2 thread 2 = 0x22 in the same cycle -> ccr thread 2 = 0x22; cc_d(tid_d=2) in that cycle = 0x22.
REQ-038 div_start_e tid 3, then rdcc_d tid 3 -> stall=1 until div_cc_vld_w2 tid 3 cc 0x0F; that cycle stall=0, cc_d=0x0F; div_pend[3] cleared next cycle.
REQ-039 tlu update_m=1 ccr_m=0xC3 with tid_m=0 -> M bypass 0xC3 for tid_d=0; stored 0xC3 after W commit with vld_w=1.
REQ-040 Assert arst_l low mid-stream with div_pend=4'b1010, CCRs nonzero -> all outputs 0 immediately, without waiting for a clock edge; TIDW=0 and CCW=4 builds pass REQ-035.
